// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, immediate formats and control decode
// Shared by decode_stage and imm_gen:
//   REG_AW        register address width of the instruction encoding
//   OP..SYSTEM    7-bit major opcodes of the RV32I base set
//   imm_fmt_e     immediate layout selector
//   dec_ctrl_t    per-instruction control bits derived from the opcode
//   decode_ctrl() instruction word -> dec_ctrl_t
package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic     use_rs1;
    logic     use_rs2;
    logic     wr_rd;
    logic     illegal;
    imm_fmt_e fmt;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] instr);
    dec_ctrl_t c;
    c.use_rs1 = 1'b0;
    c.use_rs2 = 1'b0;
    c.wr_rd   = 1'b0;
    c.illegal = 1'b0;
    c.fmt     = IMM_NONE;
    // Every RV32I opcode ends in 2'b11, so compressed or malformed
    // encodings (instr[1:0] != 2'b11) land in the default branch.
    case (instr[6:0])
      OP:     begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.wr_rd = 1'b1; end
      OP_IMM: begin c.use_rs1 = 1'b1; c.wr_rd = 1'b1; c.fmt = IMM_I; end
      LOAD:   begin c.use_rs1 = 1'b1; c.wr_rd = 1'b1; c.fmt = IMM_I; end
      STORE:  begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_S; end
      BRANCH: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = IMM_B; end
      JAL:    begin c.wr_rd = 1'b1; c.fmt = IMM_J; end
      JALR:   begin c.use_rs1 = 1'b1; c.wr_rd = 1'b1; c.fmt = IMM_I; end
      LUI:    begin c.wr_rd = 1'b1; c.fmt = IMM_U; end
      AUIPC:  begin c.wr_rd = 1'b1; c.fmt = IMM_U; end
      // FENCE/SYSTEM flow through as no-write instructions.
      FENCE:  begin c.use_rs1 = 1'b1; c.fmt = IMM_I; end
      SYSTEM: begin c.use_rs1 = 1'b1; c.fmt = IMM_I; end
      default: c.illegal = 1'b1;
    endcase
    // A write to x0 is architecturally discarded; treating it as no-write
    // keeps x0 out of the scoreboard entirely.
    if (instr[11:7] == 5'd0) c.wr_rd = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction and sign extension
// Ports:
//   instr  in   32     instruction word
//   fmt    in   enum   immediate layout (imm_fmt_e)
//   imm    out  WIDTH  sign-extended immediate; 0 for IMM_NONE
// WIDTH must be at least 32.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  imm_fmt_e         fmt,
  output logic [WIDTH-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'd0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Replicate the sign first, then drop the 32-bit value into the low bits.
  always_comb begin
    imm        = {WIDTH{imm32[31]}};
    imm[31:0]  = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with scoreboard and ID/EX register
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_valid/if_ready          fetch handshake; if_instr, if_pc payload
//   flush                      kill the instruction held in ID/EX
//   rf_regA/rf_regB            register_file read addresses (rs1/rs2 fields)
//   rf_portA/rf_portB          combinational read data
//   wb_en/wb_rd/wb_data        writeback commit, also bypassed into decode
//   ex_valid/ex_ready          ID/EX handshake towards execute
//   ex_pc..ex_illegal          registered decoded payload
module decode_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             flush,
  output logic [AW-1:0]    rf_regA,
  output logic [AW-1:0]    rf_regB,
  input  logic [WIDTH-1:0] rf_portA,
  input  logic [WIDTH-1:0] rf_portB,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rs1_val,
  output logic [WIDTH-1:0] ex_rs2_val,
  output logic [WIDTH-1:0] ex_imm,
  output logic [AW-1:0]    ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_illegal
);

  dec_ctrl_t        ctrl;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rd_dest;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             busy_rs1;
  logic             busy_rs2;
  logic             busy_rd;
  logic             hazard;
  logic             accept;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  assign ctrl    = decode_ctrl(if_instr);
  assign rs1     = AW'(if_instr[19:15]);
  assign rs2     = AW'(if_instr[24:20]);
  assign rd      = AW'(if_instr[11:7]);
  assign rd_dest = ctrl.wr_rd ? rd : '0;
  assign rf_regA = rs1;
  assign rf_regB = rs2;

  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (if_instr),
    .fmt   (ctrl.fmt),
    .imm   (imm)
  );

  // Operand select: x0 reads zero, a same-cycle writeback wins over the
  // register file (which only updates at the clock edge). Operands an
  // instruction does not use are registered as zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (ctrl.use_rs1 && rs1 != '0)
      rs1_val = (wb_en && wb_rd == rs1) ? wb_data : rf_portA;
    if (ctrl.use_rs2 && rs2 != '0)
      rs2_val = (wb_en && wb_rd == rs2) ? wb_data : rf_portB;
  end

  // A register is busy if an older instruction is still going to write it:
  // either it sits in ID/EX, or it left ID/EX and has not written back yet.
  // A writeback landing this cycle resolves a pending entry.
  always_comb begin
    busy_rs1 = (rs1 != '0) &&
               ((pending[rs1] && !(wb_en && wb_rd == rs1)) || (ex_valid && ex_rd == rs1));
    busy_rs2 = (rs2 != '0) &&
               ((pending[rs2] && !(wb_en && wb_rd == rs2)) || (ex_valid && ex_rd == rs2));
    busy_rd  = (rd != '0) &&
               ((pending[rd] && !(wb_en && wb_rd == rd)) || (ex_valid && ex_rd == rd));
    hazard   = (ctrl.use_rs1 && busy_rs1) ||
               (ctrl.use_rs2 && busy_rs2) ||
               (ctrl.wr_rd && busy_rd);
  end

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  // Clear first, then set, so an instruction leaving ID/EX for a register
  // that is being written back in the same cycle keeps its pending bit.
  // A flushed instruction never reaches execute and so never sets a bit.
  always_comb begin
    pending_next = pending;
    if (wb_en && wb_rd != '0)
      pending_next[wb_rd] = 1'b0;
    if (ex_valid && ex_ready && !flush && ex_rd != '0)
      pending_next[ex_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
      pending     <= '0;
    end else begin
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs1_val  <= rs1_val;
        ex_rs2_val  <= rs2_val;
        ex_imm      <= imm;
        ex_rd       <= rd_dest;
        ex_opcode   <= if_instr[6:0];
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_illegal  <= ctrl.illegal;
      end else if (ex_ready || flush) begin
        ex_valid <= 1'b0;
      end
      pending <= pending_next;
    end
  end

endmodule
